bar0_csr_bank: RTL



---
 rtl/bar0_csr_pkg.sv | 61 ++++++
 rtl/axi4_lite_if.sv | 33 +++
 rtl/csr_w1c_latch.sv | 29 ++
 rtl/bar0_csr_bank.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/bar0_csr_pkg.sv
// Shared definitions for the BAR0 CSR bank: register offsets, response codes
// and the byte-strobe helpers used on the write path.
package bar0_csr_pkg;

  localparam logic [11:0] ADDR_ID      = 12'h000;
  localparam logic [11:0] ADDR_SCRATCH = 12'h004;
  localparam logic [11:0] ADDR_CTRL    = 12'h008;
  localparam logic [11:0] ADDR_STATUS  = 12'h00C;
  localparam logic [11:0] ADDR_EVENT   = 12'h010;
  localparam logic [11:0] ADDR_WRCNT   = 12'h014;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } resp_t;

  typedef enum logic [2:0] {
    REG_ID, REG_SCRATCH, REG_CTRL, REG_STATUS, REG_EVENT, REG_WRCNT, REG_NONE
  } reg_idx_t;

  // Only the word address matters; byte-offset bits are dropped by the caller.
  function automatic reg_idx_t decode(input logic [11:2] word);
    reg_idx_t idx;
    case ({word, 2'b00})
      ADDR_ID:      idx = REG_ID;
      ADDR_SCRATCH: idx = REG_SCRATCH;
      ADDR_CTRL:    idx = REG_CTRL;
      ADDR_STATUS:  idx = REG_STATUS;
      ADDR_EVENT:   idx = REG_EVENT;
      ADDR_WRCNT:   idx = REG_WRCNT;
      default:      idx = REG_NONE;
    endcase
    return idx;
  endfunction

  function automatic resp_t write_resp(input reg_idx_t idx);
    resp_t r;
    case (idx)
      REG_SCRATCH, REG_CTRL, REG_EVENT: r = OKAY;
      REG_NONE:                         r = DECERR;
      default:                          r = SLVERR;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] strb_mask(input logic [3:0] strb);
    logic [31:0] m;
    for (int i = 0; i < 4; i++) m[8*i +: 8] = {8{strb[i]}};
    return m;
  endfunction

  function automatic logic [31:0] apply_strb(input logic [31:0] old_val,
                                             input logic [31:0] new_val,
                                             input logic [3:0]  strb);
    logic [31:0] m;
    m = strb_mask(strb);
    return (old_val & ~m) | (new_val & m);
  endfunction

endpackage

// File: rtl/axi4_lite_if.sv
// AXI4-Lite bundle; modport s is the slave view, m the master view.
interface axi4_lite_if #(
  parameter int DW = 32,
  parameter int AW = 32
) ();
  logic [AW-1:0]   awaddr;
  logic            awvalid;
  logic            awready;
  logic [DW-1:0]   wdata;
  logic [DW/8-1:0] wstrb;
  logic            wvalid;
  logic            wready;
  logic [1:0]      bresp;
  logic            bvalid;
  logic            bready;
  logic [AW-1:0]   araddr;
  logic            arvalid;
  logic            arready;
  logic [DW-1:0]   rdata;
  logic [1:0]      rresp;
  logic            rvalid;
  logic            rready;

  modport s (
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport m (
    output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/csr_w1c_latch.sv
// Write-1-to-clear bit vector where a set pulse beats a clear in the same
// cycle; irq is the registered OR of the stored bits.
module csr_w1c_latch #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] set,
  input  logic         clr_en,
  input  logic [W-1:0] clr_data,
  input  logic [W-1:0] clr_mask,
  output logic [W-1:0] q,
  output logic         irq
);

  logic [W-1:0] clr;
  assign clr = clr_en ? (clr_data & clr_mask) : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q   <= '0;
      irq <= 1'b0;
    end else begin
      q   <= (q & ~clr) | set;
      irq <= |q;
    end
  end

endmodule

// File: rtl/bar0_csr_bank.sv
// AXI4-Lite register bank behind BAR0: ID, scratch, control, sampled status,
// W1C events and a completed-write counter.
module bar0_csr_bank
  import bar0_csr_pkg::*;
#(
  parameter logic [31:0] ID_VALUE   = 32'hFB00_0001,
  parameter logic [31:0] CTRL_RESET = 32'h0,
  parameter int          EVT_W      = 8
) (
  input  logic             bar_clk,
  input  logic             bar_rst,
  axi4_lite_if.s           s,
  output logic [31:0]      ctrl_o,
  input  logic [31:0]      status_i,
  input  logic [EVT_W-1:0] event_i,
  output logic             irq_o
);

  logic        aw_held, w_held, awready_q, wready_q, bvalid_q;
  resp_t       bresp_q;
  logic [11:2] aw_word;
  logic [31:0] wdata_q;
  logic [3:0]  wstrb_q;

  logic        arready_q, rvalid_q;
  resp_t       rresp_q;
  logic [31:0] rdata_q;

  logic [31:0]      scratch_q, ctrl_q, status_q, wrcnt_q;
  logic [EVT_W-1:0] event_q;

  logic     aw_hs, w_hs, b_hs, ar_hs, r_hs;
  logic     commit, w_ok;
  reg_idx_t w_idx, r_idx;
  resp_t    w_resp, r_resp;
  logic [31:0] wmask, rd_mux;

  assign aw_hs = s.awvalid && awready_q;
  assign w_hs  = s.wvalid  && wready_q;
  assign b_hs  = bvalid_q  && s.bready;
  assign ar_hs = s.arvalid && arready_q;
  assign r_hs  = rvalid_q  && s.rready;

  // Both halves stay held until the response handshake, so !bvalid limits
  // each held pair to a single commit.
  assign commit = aw_held && w_held && !bvalid_q;
  assign w_idx  = decode(aw_word);
  assign w_resp = write_resp(w_idx);
  assign w_ok   = commit && (w_resp == OKAY);
  assign wmask  = strb_mask(wstrb_q);

  // NOTE: sequential state uses <= so every register samples pre-edge values.
  always_ff @(posedge bar_clk or posedge bar_rst) begin
    if (bar_rst) begin
      aw_held   <= 1'b0;
      w_held    <= 1'b0;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= OKAY;
      aw_word   <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
    end else begin
      if (aw_hs) begin
        aw_held   <= 1'b1;
        awready_q <= 1'b0;
        aw_word   <= s.awaddr[11:2];
      end else if (b_hs) begin
        aw_held   <= 1'b0;
        awready_q <= 1'b1;
      end else if (!aw_held) begin
        awready_q <= 1'b1;
      end

      if (w_hs) begin
        w_held   <= 1'b1;
        wready_q <= 1'b0;
        wdata_q  <= s.wdata;
        wstrb_q  <= s.wstrb;
      end else if (b_hs) begin
        w_held   <= 1'b0;
        wready_q <= 1'b1;
      end else if (!w_held) begin
        wready_q <= 1'b1;
      end

      if (commit) begin
        bvalid_q <= 1'b1;
        bresp_q  <= w_resp;
      end else if (b_hs) begin
        bvalid_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge bar_clk or posedge bar_rst) begin
    if (bar_rst) begin
      scratch_q <= '0;
      ctrl_q    <= CTRL_RESET;
      status_q  <= '0;
      wrcnt_q   <= '0;
    end else begin
      status_q <= status_i;
      if (w_ok) begin
        case (w_idx)
          REG_SCRATCH: scratch_q <= apply_strb(scratch_q, wdata_q, wstrb_q);
          REG_CTRL:    ctrl_q    <= apply_strb(ctrl_q, wdata_q, wstrb_q);
          default:     ;
        endcase
        wrcnt_q <= wrcnt_q + 32'd1;
      end
    end
  end

  csr_w1c_latch #(.W(EVT_W)) u_event (
    .clk      (bar_clk),
    .rst      (bar_rst),
    .set      (event_i),
    .clr_en   (w_ok && (w_idx == REG_EVENT)),
    .clr_data (wdata_q[EVT_W-1:0]),
    .clr_mask (wmask[EVT_W-1:0]),
    .q        (event_q),
    .irq      (irq_o)
  );

  assign r_idx  = decode(s.araddr[11:2]);
  assign r_resp = (r_idx == REG_NONE) ? DECERR : OKAY;

  // NOTE: rd_mux gets its default first so no branch infers a latch.
  always_comb begin
    rd_mux = '0;
    case (r_idx)
      REG_ID:      rd_mux = ID_VALUE;
      REG_SCRATCH: rd_mux = scratch_q;
      REG_CTRL:    rd_mux = ctrl_q;
      REG_STATUS:  rd_mux = status_q;
      REG_EVENT:   rd_mux[EVT_W-1:0] = event_q;
      REG_WRCNT:   rd_mux = wrcnt_q;
      default:     rd_mux = '0;
    endcase
  end

  always_ff @(posedge bar_clk or posedge bar_rst) begin
    if (bar_rst) begin
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rresp_q   <= OKAY;
      rdata_q   <= '0;
    end else if (ar_hs) begin
      arready_q <= 1'b0;
      rvalid_q  <= 1'b1;
      rresp_q   <= r_resp;
      rdata_q   <= rd_mux;
    end else if (r_hs) begin
      arready_q <= 1'b1;
      rvalid_q  <= 1'b0;
    end else if (!rvalid_q) begin
      arready_q <= 1'b1;
    end
  end

  assign s.awready = awready_q;
  assign s.wready  = wready_q;
  assign s.bvalid  = bvalid_q;
  assign s.bresp   = bresp_q;
  assign s.arready = arready_q;
  assign s.rvalid  = rvalid_q;
  assign s.rresp   = rresp_q;
  assign s.rdata   = rdata_q;
  assign ctrl_o    = ctrl_q;

  logic unused_addr_bits;
  assign unused_addr_bits = ^{s.awaddr[31:12], s.awaddr[1:0],
                              s.araddr[31:12], s.araddr[1:0]};

endmodule
